// File: rtl/noc_pkg.sv
// Shared types and YX routing helpers for the NoC switch allocator.
// Latency: pure types/functions, no state.
// Backpressure: n/a; used by combinational route logic only.
package noc_pkg;

  // Port numbering of a mesh router; indices >= 5 are extra local ports.
  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_W = 3'd2,
    PORT_E = 3'd3,
    PORT_L = 3'd4
  } port_e;

  // Per-output allocation state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alloc_state_e;

  // Addresses are carried zero-extended to this width inside the helpers.
  localparam int MAX_ADDR_W = 32;
  typedef logic [MAX_ADDR_W-1:0] addr_t;

  // Lower half of an aw-bit address (X coordinate).
  function automatic addr_t addr_lo(input addr_t a, input int aw);
    addr_t mask;
    mask = (addr_t'(1) << (aw / 2)) - addr_t'(1);
    return a & mask;
  endfunction

  // Upper half of an aw-bit address (Y coordinate).
  function automatic addr_t addr_hi(input addr_t a, input int aw);
    return addr_lo(a >> (aw / 2), aw);
  endfunction

  // YX dimension-order route: resolve Y first, then X, else deliver locally.
  function automatic port_e yx_route(input addr_t dst, input addr_t rtr, input int aw);
    port_e p;
    if (addr_hi(dst, aw) < addr_hi(rtr, aw))      p = PORT_N;
    else if (addr_hi(dst, aw) > addr_hi(rtr, aw)) p = PORT_S;
    else if (addr_lo(dst, aw) < addr_lo(rtr, aw)) p = PORT_W;
    else if (addr_lo(dst, aw) > addr_lo(rtr, aw)) p = PORT_E;
    else                                          p = PORT_L;
    return p;
  endfunction

endpackage

// File: rtl/noc_out_alloc.sv
// One output port: round-robin grant held for a whole packet, flit count, credit count.
// Latency: grant visible the cycle after the request; move_o is combinational in BUSY.
// Backpressure: stalls (grant held, count frozen) on empty input buffer or zero credit.
// Optional: NOC_ARB_VARLEN_EN ends packets on a tail flit, PKT_FLITS acting as watchdog.
module noc_out_alloc
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int PW           = 3,
  parameter int PKT_FLITS    = 4,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0] ib_empty_i,
`ifdef NOC_ARB_VARLEN_EN
  input  logic [NUM_PORTS-1:0] ib_tail_i,
`endif
  input  logic                 cc_credit_i,
  output logic                 gnt_vld_o,
  output logic [PW-1:0]        gnt_sel_o,
  output logic                 move_o
);

  localparam int CW  = (PKT_FLITS > 1) ? $clog2(PKT_FLITS) : 1;
  localparam int CRW = $clog2(CREDIT_DEPTH + 1);

  alloc_state_e   state_q, state_d;
  logic [PW-1:0]  sel_q, sel_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CRW-1:0] credit_q, credit_d;
  logic           credit_ok;
  logic           last;
  logic           pick_vld;
  logic [PW-1:0]  pick;

  assign credit_ok = (credit_q != '0);
  assign gnt_vld_o = (state_q == ST_BUSY);
  assign gnt_sel_o = sel_q;

  // Round-robin search: first requester at or after rr_ptr_q, wrapping at NUM_PORTS.
  always_comb begin : p_pick
    logic [PW:0] idx;
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!pick_vld && req_i[idx[PW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = idx[PW-1:0];
      end
    end
  end

  // Grant FSM: latch the winner in IDLE, count flit moves in BUSY, release on the last one.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    move_o   = 1'b0;
    last     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && credit_ok) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        move_o = !ib_empty_i[sel_q] && credit_ok && !reset;
        last   = (cnt_q == CW'(PKT_FLITS - 1));
`ifdef NOC_ARB_VARLEN_EN
        last   = last || ib_tail_i[sel_q];
`endif
        if (move_o) begin
          if (last) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            rr_ptr_d = (sel_q == PW'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit: spend one per move, regain one per downstream pulse, saturate at full depth.
  always_comb begin
    credit_d = credit_q;
    if (move_o && !cc_credit_i) begin
      credit_d = credit_q - 1'b1;
    end else if (cc_credit_i && !move_o && (credit_q != CRW'(CREDIT_DEPTH))) begin
      credit_d = credit_q + 1'b1;
    end
  end

  // State registers; reset drops any grant in flight without flushing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      credit_q <= CRW'(CREDIT_DEPTH);
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/noc_switch_allocator.sv
// Mesh router switch allocator: YX route, per-output wormhole round-robin grant, credit flow.
// Latency: grant 1 cycle after request; ib_read_o combinational; cc_credit_o 1 cycle after read.
// Backpressure: outputs stall on empty input buffer or exhausted downstream credit.
// Optional: NOC_ARB_VARLEN_EN adds ib_tail_i for variable-length packets.
module noc_switch_allocator
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int ADDR_W       = 8,
  parameter int PKT_FLITS    = 4,
  parameter int CREDIT_DEPTH = 4,
  localparam int PW          = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       yx_addr_router_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] yx_addr_header_i,
  input  logic [NUM_PORTS-1:0]    ib_empty_i,
`ifdef NOC_ARB_VARLEN_EN
  input  logic [NUM_PORTS-1:0]    ib_tail_i,
`endif
  input  logic [NUM_PORTS-1:0]    cc_credit_i,
  output logic [NUM_PORTS-1:0]    cc_credit_o,
  output logic [NUM_PORTS-1:0]    ib_read_o,
  output logic [NUM_PORTS-1:0]    gnt_vld_o,
  output logic [NUM_PORTS*PW-1:0] gnt_sel_o
);

  port_e                route   [NUM_PORTS];
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];  // req[j][i]: input i asks for output j
  logic [PW-1:0]        sel     [NUM_PORTS];
  logic [NUM_PORTS-1:0] move;
  logic [NUM_PORTS-1:0] engaged;
  logic [NUM_PORTS-1:0] cc_credit_q, cc_credit_d;

  // Head-flit route of every input.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = yx_route(addr_t'(yx_addr_header_i[i*ADDR_W +: ADDR_W]),
                          addr_t'(yx_addr_router_i), ADDR_W);
    end
  end

  // An input is engaged while any output holds a grant for it.
  always_comb begin
    engaged = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (gnt_vld_o[j] && (sel[j] == PW'(i))) engaged[i] = 1'b1;
      end
    end
  end

  // Request matrix; U-turns are suppressed except local-to-local.
  always_comb begin
    for (int j = 0; j < NUM_PORTS; j++) begin
      req[j] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[j][i] = !ib_empty_i[i] && !engaged[i] && (int'(route[i]) == j) &&
                    ((i != j) || (j == int'(PORT_L)));
      end
    end
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    noc_out_alloc #(
      .NUM_PORTS    (NUM_PORTS),
      .PW           (PW),
      .PKT_FLITS    (PKT_FLITS),
      .CREDIT_DEPTH (CREDIT_DEPTH)
    ) u_out (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req[j]),
      .ib_empty_i  (ib_empty_i),
`ifdef NOC_ARB_VARLEN_EN
      .ib_tail_i   (ib_tail_i),
`endif
      .cc_credit_i (cc_credit_i[j]),
      .gnt_vld_o   (gnt_vld_o[j]),
      .gnt_sel_o   (sel[j]),
      .move_o      (move[j])
    );
    assign gnt_sel_o[j*PW +: PW] = sel[j];
  end

  // Pop strobes: each input is selected by at most one moving output.
  always_comb begin
    ib_read_o = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (move[j] && (sel[j] == PW'(i))) ib_read_o[i] = 1'b1;
      end
    end
  end

  assign cc_credit_d = ib_read_o;
  assign cc_credit_o = cc_credit_q;

  // Upstream credit return: one pulse per popped flit, one cycle later.
  always_ff @(posedge clk) begin
    if (reset) cc_credit_q <= '0;
    else       cc_credit_q <= cc_credit_d;
  end

endmodule

// File: tb/tb_noc_switch_allocator.sv
// Randomised scoreboard bench for noc_switch_allocator against a packet-level reference model.
// Latency: expected outputs are queued per cycle and compared at the falling edge.
// Backpressure: random empty buffers and sparse credit phases exercise stalls.
module tb_noc_switch_allocator;

  localparam int NP   = 5;
  localparam int AW   = 8;
  localparam int PF   = 4;
  localparam int CD   = 4;
  localparam int PW   = $clog2(NP);
  localparam int NCYC = 3200;

  logic             clk;
  logic             reset;
  logic [AW-1:0]    rtr;
  logic [NP*AW-1:0] hdr;
  logic [NP-1:0]    empty;
  logic [NP-1:0]    tail;
  logic [NP-1:0]    ccin;
  logic [NP-1:0]    cc_credit_o;
  logic [NP-1:0]    ib_read_o;
  logic [NP-1:0]    gnt_vld_o;
  logic [NP*PW-1:0] gnt_sel_o;

  noc_switch_allocator #(
    .NUM_PORTS    (NP),
    .ADDR_W       (AW),
    .PKT_FLITS    (PF),
    .CREDIT_DEPTH (CD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .yx_addr_router_i (rtr),
    .yx_addr_header_i (hdr),
    .ib_empty_i       (empty),
`ifdef NOC_ARB_VARLEN_EN
    .ib_tail_i        (tail),
`endif
    .cc_credit_i      (ccin),
    .cc_credit_o      (cc_credit_o),
    .ib_read_o        (ib_read_o),
    .gnt_vld_o        (gnt_vld_o),
    .gnt_sel_o        (gnt_sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0]    rd;
    logic [NP-1:0]    vld;
    logic [NP*PW-1:0] sel;
    logic [NP-1:0]    cco;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: which input owns each output, flits sent so far, credits, rr start.
  int            owner  [NP];
  int            sent   [NP];
  int            credit [NP];
  int            rr     [NP];
  logic [NP-1:0] prev_rd;

  function automatic int route_of(input int dst, input int r);
    int half = 1 << (AW / 2);
    int dy = dst / half;
    int dx = dst % half;
    int ry = r / half;
    int rx = r % half;
    if (dy < ry) return 0;
    if (dy > ry) return 1;
    if (dx < rx) return 2;
    if (dx > rx) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NP; j++) begin
      owner[j]  = -1;
      sent[j]   = 0;
      credit[j] = CD;
      rr[j]     = 0;
    end
    prev_rd = '0;
  endtask

  // Predict this cycle's outputs from current inputs, then advance one clock.
  task automatic model_step();
    exp_t          e;
    logic [NP-1:0] mv;
    bit            eng [NP];
    int            pick, i, o;
    bit            last;
    e.rd  = '0;
    e.vld = '0;
    e.sel = '0;
    e.cco = prev_rd;
    mv    = '0;
    for (int j = 0; j < NP; j++) eng[j] = 1'b0;
    for (int j = 0; j < NP; j++) begin
      if (owner[j] >= 0) begin
        e.vld[j]          = 1'b1;
        e.sel[j*PW +: PW] = PW'(owner[j]);
        eng[owner[j]]     = 1'b1;
        if (!reset && !empty[owner[j]] && credit[j] > 0) begin
          mv[j]          = 1'b1;
          e.rd[owner[j]] = 1'b1;
        end
      end
    end
    q.push_back(e);
    if (reset) begin
      model_reset();
      return;
    end
    for (int j = 0; j < NP; j++) begin
      o = owner[j];
      if (o >= 0) begin
        if (mv[j]) begin
          sent[j]++;
          last = (sent[j] == PF);
`ifdef NOC_ARB_VARLEN_EN
          if (tail[o]) last = 1'b1;
`endif
          if (last) begin
            owner[j] = -1;
            sent[j]  = 0;
            rr[j]    = (o + 1) % NP;
          end
        end
      end else if (credit[j] > 0) begin
        pick = -1;
        for (int k = 0; k < NP; k++) begin
          i = (rr[j] + k) % NP;
          if (pick < 0 && !empty[i] && !eng[i] &&
              route_of(int'(hdr[i*AW +: AW]), int'(rtr)) == j &&
              (i != j || j == 4))
            pick = i;
        end
        owner[j] = pick;
      end
      credit[j] = credit[j] - int'(mv[j]) + int'(ccin[j]);
      if (credit[j] > CD) credit[j] = CD;
    end
    prev_rd = e.rd;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: pop one expected snapshot per cycle and compare the DUT outputs.
  initial begin
    exp_t          e;
    logic [NP*PW-1:0] mask;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e    = q.pop_front();
        mask = '0;
        for (int j = 0; j < NP; j++) if (e.vld[j]) mask[j*PW +: PW] = '1;
        check("ib_read",   32'(ib_read_o),        32'(e.rd));
        check("gnt_vld",   32'(gnt_vld_o),        32'(e.vld));
        check("gnt_sel",   32'(gnt_sel_o & mask), 32'(e.sel));
        check("cc_credit", 32'(cc_credit_o),      32'(e.cco));
      end
    end
  end

  // Stimulus: four traffic phases (mixed, all-to-south contention, credit starved, credit rich).
  initial begin
    int ph, y, x;
    int cc_pct [4] = '{50, 60, 6, 90};
    reset = 1'b1;
    rtr   = 8'h22;
    hdr   = '0;
    empty = '1;
    tail  = '0;
    ccin  = '0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      ph    = (cyc / 400) % 4;
      reset = (cyc < 2) || ($urandom_range(0, 249) == 0);
      rtr   = (ph == 3) ? 8'h13 : 8'h22;
      for (int i = 0; i < NP; i++) begin
        y = $urandom_range(0, 4);
        x = $urandom_range(0, 4);
        if (ph == 1 && i != 1) begin
          y = 5;
          x = 2;
        end
        hdr[i*AW +: AW] = AW'((y << (AW / 2)) | x);
        empty[i]        = ($urandom_range(0, 9) < ((ph == 1) ? 1 : 3));
        tail[i]         = ($urandom_range(0, 2) == 0);
      end
      for (int j = 0; j < NP; j++) ccin[j] = ($urandom_range(0, 99) < cc_pct[ph]);
      model_step();
    end
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
